// File: rtl/decode_ext_exmem_pkg.sv
// Shared encodings for the decode/extend stage and the EX/MEM pipeline register.
// Holds opcode/funct values, control encodings and the immediate-extension helper.
package decode_ext_exmem_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'b00000,
    ALU_SUB  = 5'b00001,
    ALU_AND  = 5'b00010,
    ALU_OR   = 5'b00011,
    ALU_XOR  = 5'b00100,
    ALU_NOR  = 5'b00101,
    ALU_SLT  = 5'b00110,
    ALU_SLTU = 5'b00111,
    ALU_SLL  = 5'b01000,
    ALU_SRL  = 5'b01001,
    ALU_SRA  = 5'b01010,
    ALU_LUI  = 5'b01011
  } alu_op_e;

  typedef enum logic [1:0] {
    EXT_ZERO = 2'b00,
    EXT_SIGN = 2'b01,
    EXT_LUI  = 2'b10,
    EXT_RSVD = 2'b11
  } ext_op_e;

  typedef enum logic [1:0] {
    JUMP_NONE = 2'b00,
    JUMP_J    = 2'b01,
    JUMP_JAL  = 2'b10,
    JUMP_JR   = 2'b11
  } jump_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_JUMP = 2'b11
  } branch_e;

  typedef struct packed {
    jump_e   jump;
    logic    reg_dst;
    branch_e branch;
    logic    mem_r;
    logic    mem_w;
    logic    mem2r;
    logic    reg_w;
    logic    alu_src;
    ext_op_e ext_op;
    alu_op_e alu_ctrl;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] npc;
    logic [31:0] alu_c;
    logic        zero;
    logic [1:0]  jump;
    logic [31:0] rt_data;
    logic [31:0] instr;
    logic [4:0]  reg_rd;
    logic [1:0]  branch;
    logic        memr;
    logic        memw;
    logic        regw;
    logic        mem2r;
  } exmem_t;

  // The reserved mode falls back to zero-extension so Imm32 is always defined.
  function automatic logic [31:0] extend_imm(input ext_op_e ext_op, input logic [15:0] imm16);
    logic [31:0] res;
    case (ext_op)
      EXT_SIGN: res = {{16{imm16[15]}}, imm16};
      EXT_LUI:  res = {imm16, 16'h0000};
      default:  res = {16'h0000, imm16};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/decode_ext_exmem_exmem_reg.sv
// EX/MEM pipeline register: async active-low clear, then flush, then load enable.
module exmem_reg
  import decode_ext_exmem_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   wr,
  input  logic   flush,
  input  exmem_t d_in,
  output exmem_t q_out
);

  exmem_t exmem_d;
  exmem_t exmem_q;

  always_comb begin
    exmem_d = exmem_q;
    if (flush) begin
      exmem_d = '0;
    end else if (wr) begin
      exmem_d = d_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exmem_q <= '0;
    end else begin
      exmem_q <= exmem_d;
    end
  end

  assign q_out = exmem_q;

endmodule

// File: rtl/decode_ext_exmem.sv
// Combinational instruction decode and immediate extension, plus the EX/MEM register.
// Decode and extension ignore reset; only the pipeline register is cleared by rst.
module decode_ext_exmem
  import decode_ext_exmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  OpCode,
  input  logic [5:0]  Funct,
  input  logic [15:0] Imm16,
  output logic [1:0]  jump,
  output logic        RegDst,
  output logic [1:0]  Branch,
  output logic        MemR,
  output logic        MemW,
  output logic        Mem2R,
  output logic        RegW,
  output logic        Alusrc,
  output logic [1:0]  EXTOp,
  output logic [4:0]  Aluctrl,
  output logic [31:0] Imm32,
  input  logic        EX_MEM_WR,
  input  logic        Flush,
  input  logic [31:0] NPC_IN,
  output logic [31:0] NPC_OUT,
  input  logic [31:0] ALU_C_IN,
  output logic [31:0] ALU_C_OUT,
  input  logic        ZERO_IN,
  output logic        ZERO_OUT,
  input  logic [1:0]  jump_IN,
  output logic [1:0]  jump_OUT,
  input  logic [31:0] RT_DATA_IN,
  output logic [31:0] RT_DATA_OUT,
  input  logic [31:0] INSTR_IN,
  output logic [31:0] INSTR_OUT,
  input  logic [4:0]  reg_rd_IN,
  output logic [4:0]  reg_rd_OUT,
  input  logic [1:0]  Branch_IN,
  output logic [1:0]  Branch_OUT,
  input  logic        MEMR_IN,
  output logic        MEMR_OUT,
  input  logic        MEMW_IN,
  output logic        MEMW_OUT,
  input  logic        REGW_IN,
  output logic        REGW_OUT,
  input  logic        MEM2R_IN,
  output logic        MEM2R_OUT
);

  ctrl_t   ctrl;
  logic    r_valid;
  alu_op_e r_alu;
  exmem_t  exmem_in;
  exmem_t  exmem_out;

  // R-type funct lookup; r_valid is low for unknown functs (jr is handled separately).
  always_comb begin
    r_valid = 1'b1;
    r_alu   = ALU_ADD;
    case (Funct)
      FN_ADD, FN_ADDU: r_alu = ALU_ADD;
      FN_SUB, FN_SUBU: r_alu = ALU_SUB;
      FN_AND:          r_alu = ALU_AND;
      FN_OR:           r_alu = ALU_OR;
      FN_XOR:          r_alu = ALU_XOR;
      FN_NOR:          r_alu = ALU_NOR;
      FN_SLT:          r_alu = ALU_SLT;
      FN_SLTU:         r_alu = ALU_SLTU;
      FN_SLL:          r_alu = ALU_SLL;
      FN_SRL:          r_alu = ALU_SRL;
      FN_SRA:          r_alu = ALU_SRA;
      default:         r_valid = 1'b0;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (OpCode)
      OP_RTYPE: begin
        if (Funct == FN_JR) begin
          ctrl.jump = JUMP_JR;
        end else if (r_valid) begin
          ctrl.reg_w    = 1'b1;
          ctrl.alu_ctrl = r_alu;
        end
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.reg_w   = 1'b1;
        ctrl.reg_dst = 1'b1;
        ctrl.alu_src = 1'b1;
        case (OpCode)
          OP_SLTI: begin ctrl.alu_ctrl = ALU_SLT; ctrl.ext_op = EXT_SIGN; end
          OP_ANDI: ctrl.alu_ctrl = ALU_AND;
          OP_ORI:  ctrl.alu_ctrl = ALU_OR;
          OP_XORI: ctrl.alu_ctrl = ALU_XOR;
          OP_LUI:  begin ctrl.alu_ctrl = ALU_LUI; ctrl.ext_op = EXT_LUI; end
          default: begin ctrl.alu_ctrl = ALU_ADD; ctrl.ext_op = EXT_SIGN; end
        endcase
      end
      OP_LW: begin
        ctrl.mem_r   = 1'b1;
        ctrl.mem2r   = 1'b1;
        ctrl.reg_w   = 1'b1;
        ctrl.reg_dst = 1'b1;
        ctrl.alu_src = 1'b1;
        ctrl.ext_op  = EXT_SIGN;
      end
      OP_SW: begin
        ctrl.mem_w   = 1'b1;
        ctrl.alu_src = 1'b1;
        ctrl.ext_op  = EXT_SIGN;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.branch   = (OpCode == OP_BEQ) ? BR_BEQ : BR_BNE;
        ctrl.alu_ctrl = ALU_SUB;
        ctrl.ext_op   = EXT_SIGN;
      end
      OP_J: begin
        ctrl.branch = BR_JUMP;
        ctrl.jump   = JUMP_J;
      end
      OP_JAL: begin
        ctrl.branch = BR_JUMP;
        ctrl.jump   = JUMP_JAL;
      end
      default: ctrl = '0;
    endcase
  end

  assign jump    = ctrl.jump;
  assign RegDst  = ctrl.reg_dst;
  assign Branch  = ctrl.branch;
  assign MemR    = ctrl.mem_r;
  assign MemW    = ctrl.mem_w;
  assign Mem2R   = ctrl.mem2r;
  assign RegW    = ctrl.reg_w;
  assign Alusrc  = ctrl.alu_src;
  assign EXTOp   = ctrl.ext_op;
  assign Aluctrl = ctrl.alu_ctrl;
  assign Imm32   = extend_imm(ctrl.ext_op, Imm16);

  assign exmem_in = '{
    npc:     NPC_IN,
    alu_c:   ALU_C_IN,
    zero:    ZERO_IN,
    jump:    jump_IN,
    rt_data: RT_DATA_IN,
    instr:   INSTR_IN,
    reg_rd:  reg_rd_IN,
    branch:  Branch_IN,
    memr:    MEMR_IN,
    memw:    MEMW_IN,
    regw:    REGW_IN,
    mem2r:   MEM2R_IN
  };

  exmem_reg u_exmem_reg (
    .clk   (clk),
    .rst   (rst),
    .wr    (EX_MEM_WR),
    .flush (Flush),
    .d_in  (exmem_in),
    .q_out (exmem_out)
  );

  assign NPC_OUT     = exmem_out.npc;
  assign ALU_C_OUT   = exmem_out.alu_c;
  assign ZERO_OUT    = exmem_out.zero;
  assign jump_OUT    = exmem_out.jump;
  assign RT_DATA_OUT = exmem_out.rt_data;
  assign INSTR_OUT   = exmem_out.instr;
  assign reg_rd_OUT  = exmem_out.reg_rd;
  assign Branch_OUT  = exmem_out.branch;
  assign MEMR_OUT    = exmem_out.memr;
  assign MEMW_OUT    = exmem_out.memw;
  assign REGW_OUT    = exmem_out.regw;
  assign MEM2R_OUT   = exmem_out.mem2r;

endmodule

// File: tb/tb_decode_ext_exmem.sv
// Randomized bench for decode_ext_exmem against a mnemonic-level reference model.
module tb_decode_ext_exmem;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  OpCode, Funct;
  logic [15:0] Imm16;
  logic [1:0]  jump, Branch, EXTOp;
  logic        RegDst, MemR, MemW, Mem2R, RegW, Alusrc;
  logic [4:0]  Aluctrl;
  logic [31:0] Imm32;
  logic        EX_MEM_WR, Flush;
  logic [31:0] NPC_IN, NPC_OUT, ALU_C_IN, ALU_C_OUT, RT_DATA_IN, RT_DATA_OUT, INSTR_IN, INSTR_OUT;
  logic        ZERO_IN, ZERO_OUT, MEMR_IN, MEMR_OUT, MEMW_IN, MEMW_OUT;
  logic        REGW_IN, REGW_OUT, MEM2R_IN, MEM2R_OUT;
  logic [1:0]  jump_IN, jump_OUT, Branch_IN, Branch_OUT;
  logic [4:0]  reg_rd_IN, reg_rd_OUT;

  logic [141:0] reg_in;
  logic [141:0] reg_exp;
  logic [141:0] reg_obs;
  logic [16:0]  dec_obs;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign {NPC_IN, ALU_C_IN, ZERO_IN, jump_IN, RT_DATA_IN, INSTR_IN, reg_rd_IN, Branch_IN,
          MEMR_IN, MEMW_IN, REGW_IN, MEM2R_IN} = reg_in;
  assign reg_obs = {NPC_OUT, ALU_C_OUT, ZERO_OUT, jump_OUT, RT_DATA_OUT, INSTR_OUT, reg_rd_OUT,
                    Branch_OUT, MEMR_OUT, MEMW_OUT, REGW_OUT, MEM2R_OUT};
  assign dec_obs = {jump, RegDst, Branch, MemR, MemW, Mem2R, RegW, Alusrc, EXTOp, Aluctrl};

  decode_ext_exmem dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .Funct(Funct), .Imm16(Imm16),
    .jump(jump), .RegDst(RegDst), .Branch(Branch), .MemR(MemR), .MemW(MemW),
    .Mem2R(Mem2R), .RegW(RegW), .Alusrc(Alusrc), .EXTOp(EXTOp), .Aluctrl(Aluctrl),
    .Imm32(Imm32), .EX_MEM_WR(EX_MEM_WR), .Flush(Flush),
    .NPC_IN(NPC_IN), .NPC_OUT(NPC_OUT), .ALU_C_IN(ALU_C_IN), .ALU_C_OUT(ALU_C_OUT),
    .ZERO_IN(ZERO_IN), .ZERO_OUT(ZERO_OUT), .jump_IN(jump_IN), .jump_OUT(jump_OUT),
    .RT_DATA_IN(RT_DATA_IN), .RT_DATA_OUT(RT_DATA_OUT), .INSTR_IN(INSTR_IN),
    .INSTR_OUT(INSTR_OUT), .reg_rd_IN(reg_rd_IN), .reg_rd_OUT(reg_rd_OUT),
    .Branch_IN(Branch_IN), .Branch_OUT(Branch_OUT), .MEMR_IN(MEMR_IN), .MEMR_OUT(MEMR_OUT),
    .MEMW_IN(MEMW_IN), .MEMW_OUT(MEMW_OUT), .REGW_IN(REGW_IN), .REGW_OUT(REGW_OUT),
    .MEM2R_IN(MEM2R_IN), .MEM2R_OUT(MEM2R_OUT)
  );

  task automatic checkOutput(input string tag, input logic [159:0] observed, input logic [159:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Instruction name from the encoding; anything unrecognised is a nop.
  function automatic string mnemonic(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000:
        case (fn)
          6'b100000: return "add";   6'b100001: return "addu";
          6'b100010: return "sub";   6'b100011: return "subu";
          6'b100100: return "and";   6'b100101: return "or";
          6'b100110: return "xor";   6'b100111: return "nor";
          6'b101010: return "slt";   6'b101011: return "sltu";
          6'b000000: return "sll";   6'b000010: return "srl";
          6'b000011: return "sra";   6'b001000: return "jr";
          default:   return "nop";
        endcase
      6'b001000: return "addi";  6'b001001: return "addiu";
      6'b001010: return "slti";  6'b001100: return "andi";
      6'b001101: return "ori";   6'b001110: return "xori";
      6'b001111: return "lui";   6'b100011: return "lw";
      6'b101011: return "sw";    6'b000100: return "beq";
      6'b000101: return "bne";   6'b000010: return "j";
      6'b000011: return "jal";
      default:   return "nop";
    endcase
  endfunction

  function automatic logic [4:0] alu_of(input string m);
    case (m)
      "sub", "subu", "beq", "bne": return 5'd1;
      "and", "andi":               return 5'd2;
      "or", "ori":                 return 5'd3;
      "xor", "xori":               return 5'd4;
      "nor":                       return 5'd5;
      "slt", "slti":               return 5'd6;
      "sltu":                      return 5'd7;
      "sll":                       return 5'd8;
      "srl":                       return 5'd9;
      "sra":                       return 5'd10;
      "lui":                       return 5'd11;
      default:                     return 5'd0;
    endcase
  endfunction

  // Packed as {jump, RegDst, Branch, MemR, MemW, Mem2R, RegW, Alusrc, EXTOp, Aluctrl}.
  function automatic logic [16:0] expected_decode(input string m);
    logic [1:0] jmp = 0, br = 0, ext = 0;
    logic rdst = 0, mr = 0, mw = 0, m2r = 0, rw = 0, asrc = 0;
    logic [4:0] alu = 0;
    case (m)
      "add", "addu", "sub", "subu", "and", "or", "xor", "nor", "slt", "sltu", "sll", "srl", "sra":
        begin rw = 1; alu = alu_of(m); end
      "addi", "addiu", "slti": begin rw = 1; rdst = 1; asrc = 1; alu = alu_of(m); ext = 1; end
      "andi", "ori", "xori":   begin rw = 1; rdst = 1; asrc = 1; alu = alu_of(m); ext = 0; end
      "lui":  begin rw = 1; rdst = 1; asrc = 1; alu = alu_of(m); ext = 2; end
      "lw":   begin mr = 1; m2r = 1; rw = 1; rdst = 1; asrc = 1; ext = 1; end
      "sw":   begin mw = 1; asrc = 1; ext = 1; end
      "beq":  begin br = 1; alu = alu_of(m); ext = 1; end
      "bne":  begin br = 2; alu = alu_of(m); ext = 1; end
      "j":    begin br = 3; jmp = 1; end
      "jal":  begin br = 3; jmp = 2; end
      "jr":   jmp = 3;
      default: ;
    endcase
    return {jmp, rdst, br, mr, mw, m2r, rw, asrc, ext, alu};
  endfunction

  function automatic logic [31:0] expected_imm(input logic [1:0] ext, input logic [15:0] imm);
    int signed s;
    case (ext)
      2'd1:    begin s = $signed(imm); return 32'(s); end
      2'd2:    return 32'(imm) * 32'd65536;
      default: return 32'(imm);
    endcase
  endfunction

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic [15:0] imm);
    logic [16:0] exp_dec;
    OpCode = op;
    Funct  = fn;
    Imm16  = imm;
    #1;
    exp_dec = expected_decode(mnemonic(op, fn));
    checkOutput($sformatf("decode_%s", mnemonic(op, fn)), 160'(dec_obs), 160'(exp_dec));
    checkOutput("imm32", 160'(Imm32), 160'(expected_imm(exp_dec[6:5], imm)));
  endtask

  task automatic regCycle(input logic wr, input logic fl, input logic [141:0] data, input string tag);
    @(negedge clk);
    EX_MEM_WR = wr;
    Flush     = fl;
    reg_in    = data;
    @(posedge clk);
    if (fl) reg_exp = '0;
    else if (wr) reg_exp = data;
    #1;
    checkOutput(tag, 160'(reg_obs), 160'(reg_exp));
  endtask

  function automatic logic [141:0] rand_bus();
    logic [159:0] r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[141:0];
  endfunction

  logic [5:0] legal_ops [14] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                                 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
  logic [5:0] legal_fns [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08};

  initial begin
    logic [141:0] d;
    logic [5:0]   op, fn;
    rst = 1'b0; OpCode = 0; Funct = 0; Imm16 = 0;
    EX_MEM_WR = 0; Flush = 0; reg_in = '0; reg_exp = '0;
    #12;
    checkOutput("reset_state", 160'(reg_obs), 160'(0));
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(6'b001000, 6'b000000, 16'hFFFC);
    checkOutput("addi_imm32", 160'(Imm32), 160'(32'hFFFFFFFC));
    checkOutput("addi_ctrl", 160'({RegW, RegDst, Alusrc, Aluctrl, EXTOp}), 160'({3'b111, 5'b00000, 2'b01}));
    applyStimulus(6'b001111, 6'b000000, 16'h1234);
    checkOutput("lui_imm32", 160'({EXTOp, Aluctrl, Imm32}), 160'({2'b10, 5'b01011, 32'h12340000}));
    applyStimulus(6'b001101, 6'b000000, 16'h8000);
    checkOutput("ori_imm32", 160'(Imm32), 160'(32'h00008000));
    applyStimulus(6'b000000, 6'b001000, 16'h0000);
    checkOutput("jr_ctrl", 160'({jump, RegW}), 160'({2'b11, 1'b0}));
    applyStimulus(6'b000101, 6'b000000, 16'h0010);
    checkOutput("bne_ctrl", 160'({Branch, Aluctrl}), 160'({2'b10, 5'b00001}));
    applyStimulus(6'b000011, 6'b000000, 16'h0000);
    checkOutput("jal_ctrl", 160'({Branch, jump}), 160'({2'b11, 2'b10}));
    applyStimulus(6'b111111, 6'b000000, 16'hABCD);
    applyStimulus(6'b000000, 6'b111111, 16'hABCD);

    d = rand_bus();
    d[109:78] = 32'hDEADBEEF;
    d[1] = 1'b1;
    regCycle(1'b1, 1'b0, d, "load");
    checkOutput("load_aluc_regw", 160'({ALU_C_OUT, REGW_OUT}), 160'({32'hDEADBEEF, 1'b1}));
    regCycle(1'b0, 1'b0, ~d, "hold");
    checkOutput("hold_aluc_regw", 160'({ALU_C_OUT, REGW_OUT}), 160'({32'hDEADBEEF, 1'b1}));

    d = rand_bus(); d[141] = 1'b1;
    regCycle(1'b1, 1'b1, d, "flush_with_wr");

    d = rand_bus(); d[141] = 1'b1;
    regCycle(1'b1, 1'b0, d, "preload");
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    reg_exp = '0;
    checkOutput("async_reset", 160'(reg_obs), 160'(0));
    applyStimulus(6'b100011, 6'b000000, 16'h8001);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 13)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_fns[$urandom_range(0, 13)];
      applyStimulus(op, fn, 16'($urandom));
    end

    for (int i = 0; i < 300; i++) begin
      regCycle(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), rand_bus(), "exmem_rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
